spi_master: RTL and testbench

- Mode-0 (CPOL=0, CPHA=0) SPI master, one byte per transaction, MSB first.
- Drives sck/mosi/ssel and samples miso.
- Counterpart for the team's SPI slave echo design: used on-board to exercise the slave, and as the bus initiator in the next system top.
- Byte-level start/busy/done handshake on the clk_25mhz domain.

---
 rtl/spi_master.sv | 169 ++++++++++++++++
 tb/tb_spi_master.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// Mode-0 SPI master, one byte per transaction, MSB first, fully registered outputs.
// Optional back-to-back bytes under one ssel when SPI_MASTER_BURST_EN is defined.
module spi_master #(
    parameter int CLK_DIV      = 4,
    parameter int SETUP_CYCLES = 4,
    parameter int GAP_CYCLES   = 4
) (
    input  logic       clk_25mhz,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx_data,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_data,
    output logic       sck,
    output logic       mosi,
    input  logic       miso,
    output logic       ssel
);

    localparam int MAX1 = (CLK_DIV > SETUP_CYCLES) ? CLK_DIV : SETUP_CYCLES;
    localparam int MAXC = (MAX1 > GAP_CYCLES) ? MAX1 : GAP_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    tx_sh, tx_sh_n;
    logic [7:0]    rx_sh, rx_sh_n;
    logic          sck_n, ssel_n, mosi_n, busy_n, done_n;
    logic [7:0]    rx_data_n;

    always_ff @(posedge clk_25mhz or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            tx_sh   <= '0;
            rx_sh   <= '0;
            sck     <= 1'b0;
            ssel    <= 1'b1;
            mosi    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rx_data <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_cnt <= bit_cnt_n;
            tx_sh   <= tx_sh_n;
            rx_sh   <= rx_sh_n;
            sck     <= sck_n;
            ssel    <= ssel_n;
            mosi    <= mosi_n;
            busy    <= busy_n;
            done    <= done_n;
            rx_data <= rx_data_n;
        end
    end

    // Next values of every output are computed here and registered above,
    // so start and miso never reach an output combinationally.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_cnt_n = bit_cnt;
        tx_sh_n   = tx_sh;
        rx_sh_n   = rx_sh;
        sck_n     = sck;
        ssel_n    = ssel;
        mosi_n    = mosi;
        busy_n    = busy;
        done_n    = 1'b0;
        rx_data_n = rx_data;

        case (state)
            IDLE: begin
                cnt_n     = '0;
                bit_cnt_n = '0;
                if (start) begin
                    tx_sh_n = tx_data;
                    mosi_n  = tx_data[7];
                    ssel_n  = 1'b0;
                    busy_n  = 1'b1;
                    state_n = SETUP;
                end
            end

            SETUP: begin
                if (cnt == SETUP_LAST) begin
                    cnt_n   = '0;
                    state_n = XFER;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            XFER: begin
                if (cnt == DIV_LAST) begin
                    cnt_n = '0;
                    sck_n = ~sck;
                    if (!sck) begin
                        rx_sh_n = {rx_sh[6:0], miso};
                    end else if (bit_cnt == 3'd7) begin
                        bit_cnt_n = '0;
                        state_n   = HOLD;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                        tx_sh_n   = {tx_sh[6:0], 1'b0};
                        mosi_n    = tx_sh[6];
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            HOLD: begin
                if (cnt == DIV_LAST) begin
                    cnt_n     = '0;
                    done_n    = 1'b1;
                    rx_data_n = rx_sh;
`ifdef SPI_MASTER_BURST_EN
                    if (start) begin
                        tx_sh_n = tx_data;
                        mosi_n  = tx_data[7];
                        state_n = XFER;
                    end else begin
                        ssel_n  = 1'b1;
                        mosi_n  = 1'b0;
                        state_n = GAP;
                    end
`else
                    ssel_n  = 1'b1;
                    mosi_n  = 1'b0;
                    state_n = GAP;
`endif
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_n   = '0;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                sck_n   = 1'b0;
                ssel_n  = 1'b1;
                mosi_n  = 1'b0;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: two instances (CLK_DIV 4 and 1) each driven by random
// and directed bytes against a behavioural SPI slave; a monitor checks every done pulse.
module tb_spi_master;

    localparam int CP = 40;

    typedef struct packed {
        logic [7:0] tx;
        logic [7:0] rx;
        int         t;
    } exp_t;

    logic clk_25mhz;
    int   errors;
    int   checks;

    initial clk_25mhz = 1'b0;
    always #(CP / 2) clk_25mhz = ~clk_25mhz;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int D = (g == 0) ? 4 : 1;
        localparam int S = (g == 0) ? 4 : 1;
        localparam int G = (g == 0) ? 4 : 3;

        logic       rst, start, busy, done, sck, mosi, miso, ssel;
        logic [7:0] tx_data, rx_data;
        int         cyc;
        bit         fin;

        spi_master #(.CLK_DIV(D), .SETUP_CYCLES(S), .GAP_CYCLES(G)) dut (
            .clk_25mhz(clk_25mhz),
            .rst      (rst),
            .start    (start),
            .tx_data  (tx_data),
            .busy     (busy),
            .done     (done),
            .rx_data  (rx_data),
            .sck      (sck),
            .mosi     (mosi),
            .miso     (miso),
            .ssel     (ssel)
        );

        always @(posedge clk_25mhz) cyc <= cyc + 1;

        // Behavioural slave: shifts out cur MSB first, captures mosi on rising sck.
        // On ssel falling it replies with resp; on a burst continuation with the echo byte.
        logic [7:0]   resp, cur, sh, last_seen;
        bit           echo;
        int           nbit;
        int           bad_cnt;
        time          last_rise;
        logic         ssel_p, sck_p;
        byte unsigned seen_q[$];
        exp_t         exp_q[$];

        initial begin
            nbit = 0; bad_cnt = 0; last_rise = 0; miso = 1'b0;
            ssel_p = 1'b1; sck_p = 1'b0; cur = '0; sh = '0; last_seen = '0;
            forever begin
                @(ssel or sck);
                if (ssel_p === 1'b1 && ssel === 1'b0) begin
                    nbit = 0;
                    cur  = resp;
                    miso = cur[7];
                end
                if (sck_p === 1'b0 && sck === 1'b1) begin
                    if (ssel !== 1'b0) bad_cnt++;
                    if (nbit > 0 && ($time - last_rise) != time'(2 * D * CP)) bad_cnt++;
                    last_rise = $time;
                    sh = {sh[6:0], mosi};
                    nbit++;
                    if (nbit == 8) begin
                        seen_q.push_back(sh);
                        last_seen = sh;
                    end
                end else if (sck_p === 1'b1 && sck === 1'b0 && ssel === 1'b0) begin
                    if (nbit < 8) begin
                        miso = cur[7 - nbit];
                    end else begin
                        nbit = 0;
                        cur  = echo ? last_seen : resp;
                        miso = cur[7];
                    end
                end
                ssel_p = ssel;
                sck_p  = sck;
            end
        end

        // Monitor: every done pops one expectation; busy must fall G cycles after done.
        initial begin
            int   last_done;
            logic busy_p;
            exp_t e;
            int   s;
            last_done = 0;
            busy_p    = 1'b0;
            forever begin
                @(negedge clk_25mhz);
                if (rst === 1'b1) begin
                    busy_p = 1'b0;
                end else begin
                    if (done === 1'b1) begin
                        if (exp_q.size() == 0) begin
                            check(1'b0, "unexpected_done", int'(rx_data), 0);
                        end else begin
                            e = exp_q.pop_front();
                            s = 256;
                            if (seen_q.size() != 0) s = int'(seen_q.pop_front());
                            check(rx_data == e.rx, "rx_data", int'(rx_data), int'(e.rx));
                            check(cyc == e.t, "done_cycle", cyc, e.t);
                            check(s == int'(e.tx), "mosi_byte", s, int'(e.tx));
                            check(bad_cnt == 0, "sck_shape", bad_cnt, 0);
                        end
                        last_done = cyc;
                    end
                    if (busy_p === 1'b1 && busy === 1'b0) begin
                        check(cyc == last_done + G, "busy_fall", cyc, last_done + G);
                        check({ssel, mosi} == 2'b10, "gap_lines", int'({ssel, mosi}), 2);
                    end
                    busy_p = busy;
                end
            end
        end

        task automatic check_idle(input string name);
            check({sck, ssel, mosi, busy, done, rx_data} == 13'b0_1_0_0_0_00000000, name,
                  int'({sck, ssel, mosi, busy, done, rx_data}), 13'h0800);
        endtask

        task automatic send(input logic [7:0] b, input logic [7:0] r, input bit want_done,
                            output int t0);
            int n;
            n = 0;
            while (busy !== 1'b0 && n < 500) begin
                @(negedge clk_25mhz);
                n++;
            end
            check(busy === 1'b0, "idle_before_start", int'(busy), 0);
            resp    = r;
            start   = 1'b1;
            tx_data = b;
            @(negedge clk_25mhz);
            start   = 1'b0;
            tx_data = 8'($urandom);
            t0      = cyc;
            check({busy, ssel, mosi} == {2'b10, b[7]}, "accept_lines",
                  int'({busy, ssel, mosi}), int'({2'b10, b[7]}));
            if (want_done) exp_q.push_back('{tx: b, rx: r, t: t0 + S + 17 * D});
        endtask

        task automatic wait_idle();
            int n;
            n = 0;
            while ((busy !== 1'b0 || exp_q.size() != 0) && n < 2000) begin
                @(negedge clk_25mhz);
                n++;
            end
            check(busy === 1'b0 && exp_q.size() == 0, "complete", exp_q.size(), 0);
        endtask

        initial begin
            int t0;
            int n;
            int target;
            fin = 1'b0; echo = 1'b0; resp = '0;
            rst = 1'b0; start = 1'b0; tx_data = '0;
            #5 rst = 1'b1;
            #1 check_idle("reset_async");
            repeat (3) @(negedge clk_25mhz);
            rst = 1'b0;

            send(8'hA5, 8'h3C, 1'b1, t0);
            wait_idle();

            for (int i = 0; i < 6; i++) begin
                send(8'($urandom), 8'($urandom), 1'b1, t0);
                repeat ($urandom_range(0, 3)) @(negedge clk_25mhz);
            end
            wait_idle();

            // start pulses mid-byte must be ignored
            send(8'h12, 8'($urandom), 1'b1, t0);
            repeat (S + 4 * D) @(negedge clk_25mhz);
            start = 1'b1; tx_data = 8'hFF;
            @(negedge clk_25mhz);
            start = 1'b0;
            wait_idle();

            send(8'h81, 8'hFF, 1'b1, t0);
            wait_idle();

            send(8'hC3, 8'($urandom), 1'b0, t0);
            n = 0;
            while (nbit < 3 && n < 200) begin
                @(negedge clk_25mhz);
                n++;
            end
            check(nbit >= 3, "third_rise_seen", nbit, 3);
            #7 rst = 1'b1;
            #1 check_idle("reset_mid_xfer");
            repeat (3) @(negedge clk_25mhz);
            rst = 1'b0;
            repeat (20 * D + 10) @(negedge clk_25mhz);
            check_idle("no_done_after_abort");
            send(8'h5A, 8'($urandom), 1'b1, t0);
            wait_idle();

            // Second start lands in the last HOLD cycle of the first byte
            echo = 1'b1;
            send(8'h01, 8'h00, 1'b1, t0);
            target = t0 + S + 17 * D - 1;
            n = 0;
            while (cyc < target && n < 500) begin
                @(negedge clk_25mhz);
                n++;
            end
            check(cyc == target, "reach_hold_end", cyc, target);
            start = 1'b1; tx_data = 8'h02;
`ifdef SPI_MASTER_BURST_EN
            exp_q.push_back('{tx: 8'h02, rx: 8'h01, t: t0 + S + 34 * D});
`endif
            @(negedge clk_25mhz);
            start = 1'b0;
`ifdef SPI_MASTER_BURST_EN
            check({ssel, mosi} == 2'b00, "burst_lines", int'({ssel, mosi}), 0);
`else
            check({ssel, mosi} == 2'b10, "hold_exit_lines", int'({ssel, mosi}), 2);
`endif
            wait_idle();
            echo = 1'b0;
            fin  = 1'b1;
        end
    end

    initial begin
        int n;
        n = 0;
        while (!(u[0].fin && u[1].fin) && n < 5000) begin
            #(100);
            n++;
        end
        if (!(u[0].fin && u[1].fin)) begin
            checks++;
            errors++;
            $display("FAIL timeout: fin=%0d%0d, wanted 11", u[0].fin, u[1].fin);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
